mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Iterative shift-add multiplier sequencer for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Sits in EX. The decoder's is_mul and mul_src1_signed/mul_src2_signed/mul_sel_high qualifiers drive it.
- Holds the pipeline with o_stall while a multiply runs, then presents the 32-bit result for rd write-back (wr_reg_from_mul path).
- Replaces a single-cycle 32x32 multiplier, to cut area and critical path.

Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle. Legal values are 1, 2 and 4. N = XLEN/BITS_PER_CYCLE iterations.

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  synchronous reset, active-high
- i_start  input  1  EX holds a valid mul instruction (is_mul and EX valid). Sampled only in IDLE.
- i_flush  input  1  kill the EX instruction (branch/jump redirect or trap)
- i_src1  input  XLEN  rs1 operand, already forwarded
- i_src2  input  XLEN  rs2 operand, already forwarded
- i_src1_signed  input  1  treat src1 as two's complement
- i_src2_signed  input  1  treat src2 as two's complement
- i_sel_high  input  1  1 = return product[2*XLEN-1:XLEN], 0 = return product[XLEN-1:0]
- o_stall  output  1  freeze IF/ID/EX. Combinational.
- o_busy  output  1  state is CALC or DONE. Registered.
- o_done  output  1  one-cycle pulse; o_result is valid
- o_result  output  XLEN  selected product half, held until the next accepted start

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE; o_done=0; o_result=0; o_busy=0; internal product, multiplicand and counter = 0. Reset mid-operation abandons the operation with no o_done.
- States: IDLE, CALC, DONE. Encoded 2-bit.
- IDLE, when i_start=1 and i_flush=0 (cycle T):
  - Latch |src1| and |src2|. The magnitude is the negation when the signed flag=1 and the MSB=1; otherwise the raw value.
  - Latch neg = (s1 & src1[XLEN-1]) ^ (s2 & src2[XLEN-1]) and sel_high.
  - Clear the 2*XLEN product register and the counter.
  - If either operand = 0: next state DONE (fast path). Otherwise next state CALC.
- CALC, each cycle:
  - Add (multiplier low BITS_PER_CYCLE bits x multiplicand) into the product upper half, then shift the product right by BITS_PER_CYCLE.
  - Consume the multiplier bits and increment the counter.
  - After step N (counter = N-1 at the edge): negate the 64-bit product if neg, register the selected half into o_result, next state DONE.
- DONE: o_done=1 for exactly this cycle. o_result is valid. Next state IDLE unconditionally. i_start is ignored in DONE, because the instruction advances out of EX this cycle.
- o_stall = (IDLE & i_start & ~i_flush) | CALC. It is 0 in DONE, so the pipeline advances with o_result in the same cycle.
- Latency, BITS_PER_CYCLE=1: start T, CALC T+1..T+32, o_done at T+33. o_stall is high for T..T+32 (33 cycles).
- Latency, fast path: o_done at T+1. o_stall is high only at T.
- Flush:
  - i_flush=1 in any state forces state IDLE at the next edge. No o_done is produced and o_result keeps its old value.
  - i_flush with i_start in the same IDLE cycle: flush wins and nothing starts. o_stall=0.
- Back-to-back muls: the second start is accepted in the IDLE cycle after DONE (T+34). There is no extra bubble beyond that.
- Operand changes while CALC: ignored, because operands are latched at start.
- Arithmetic: the unsigned core is exact for all XLEN-bit magnitudes, including 0x80000000 (magnitude 2^31). The final negation is on the full 2*XLEN bits. MULHSU uses s1=1, s2=0. Overflow cases need no special handling; RV32M defines the results.

Decomposition:
- defines.vh gains:
  - MUL_STATE_WIDTH and the IDLE/CALC/DONE encodings
  - MUL_CNT_WIDTH = clog2(N)
  - the legal-BITS_PER_CYCLE check as a generate-time error
- One sub-module, mul_step: combinational radix-2^BITS_PER_CYCLE add-and-shift of {product, multiplier bits, multiplicand} -> next product. mul_seq instantiates it once.
- The FSM, sign handling and result select stay in mul_seq.

Test Plan:
- MUL 7 x 0xFFFFFFFD (s1=s2=1, sel_high=0), start at T -> o_stall high T..T+32; o_done at T+33; o_result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 signed -> o_result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF (signed) x 0xFFFFFFFF (unsigned) -> product 0xFFFFFFFF00000001; o_result=0xFFFFFFFF.
- Zero fast path: MUL 0 x 0x12345678 at T -> o_done at T+1; o_result=0; o_stall high only at T.
- Flush mid-CALC: start at T, i_flush=1 at T+5 -> IDLE at T+6; no o_done ever; o_result unchanged. A new start at T+6 completes normally at T+39.
- Reset mid-CALC at T+10 -> all outputs 0 at T+11; i_start=1 with i_flush=1 in the same cycle -> o_stall=0 and no operation is started.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier sequencer.
package mul_seq_pkg;

    localparam int MUL_STATE_WIDTH = 2;

    typedef enum logic [MUL_STATE_WIDTH-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    function automatic int mul_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit mul_bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BITS_PER_CYCLE add-and-shift step of the multiplier; purely combinational.
// The multiplier digit is taken from the low bits of the product's lower half.
module mul_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [XLEN-1:0]   i_acc,
    input  logic [XLEN-1:0]   i_lo,
    input  logic [XLEN-1:0]   i_mcand,
    output logic [2*XLEN-1:0] o_prod
);
    localparam int B = BITS_PER_CYCLE;

    logic [B-1:0]      w_digit;
    logic [XLEN+B-1:0] w_pp;
    logic [XLEN+B-1:0] w_sum;

    assign w_digit = i_lo[B-1:0];
    assign w_pp    = {{B{1'b0}}, i_mcand} * {{XLEN{1'b0}}, w_digit};
    // Cannot overflow: acc + digit*mcand < 2^B * 2^XLEN.
    assign w_sum   = {{B{1'b0}}, i_acc} + w_pp;
    assign o_prod  = {w_sum, i_lo[XLEN-1:B]};

endmodule

// File: rtl/mul_seq.sv
// Iterative RV32M multiplier: XLEN/BITS_PER_CYCLE CALC cycles plus a DONE cycle, one cycle if an operand is 0.
// o_stall holds the pipeline from the start cycle through CALC; drops in DONE so EX advances with o_result.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_src1_signed,
    input  logic            i_src2_signed,
    input  logic            i_sel_high,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = mul_cnt_width(N);
    localparam int PW = 2 * XLEN;

    generate
        if (!mul_bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
            $error("mul_seq: BITS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic s);
        return (s && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

    mul_state_t      r_state;
    logic [PW-1:0]   r_prod;
    logic [XLEN-1:0] r_mcand;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic            r_sel_high;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_neg;
    logic [PW-1:0]   w_next_prod;
    logic [PW-1:0]   w_final;
    logic            w_last;

    assign w_accept = (r_state == ST_IDLE) && i_start && !i_flush;
    assign w_mag1   = f_mag(i_src1, i_src1_signed);
    assign w_mag2   = f_mag(i_src2, i_src2_signed);
    assign w_neg    = (i_src1_signed & i_src1[XLEN-1]) ^ (i_src2_signed & i_src2[XLEN-1]);
    assign w_last   = (r_cnt == CW'(N - 1));

    mul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_acc   (r_prod[PW-1:XLEN]),
        .i_lo    (r_prod[XLEN-1:0]),
        .i_mcand (r_mcand),
        .o_prod  (w_next_prod)
    );

    assign w_final = r_neg ? (~w_next_prod + PW'(1)) : w_next_prod;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_sel_high <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (i_start) begin
                        // Upper half accumulates; lower half starts as the multiplier and shifts out.
                        r_prod     <= {{XLEN{1'b0}}, w_mag2};
                        r_mcand    <= w_mag1;
                        r_cnt      <= '0;
                        r_neg      <= w_neg;
                        r_sel_high <= i_sel_high;
                        r_busy     <= 1'b1;
                        if (i_src1 == '0 || i_src2 == '0) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_prod <= w_next_prod;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= r_sel_high ? w_final[PW-1:XLEN] : w_final[XLEN-1:0];
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall  = w_accept || (r_state == ST_CALC);
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: latency, stall window, signed variants, fast path, flush and reset.
module tb_mul_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        s1;
    logic        s2;
    logic        sel_high;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mul_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_flush       (flush),
        .i_src1        (src1),
        .i_src2        (src2),
        .i_src1_signed (s1),
        .i_src2_signed (s2),
        .i_sel_high    (sel_high),
        .o_stall       (o_stall),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: issues one multiply, reports result, done latency and stall-cycle count.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                          input logic h, output logic [31:0] res, output int lat, output int stalls);
        @(posedge clk); #1;
        src1 = a; src2 = b; s1 = sa; s2 = sb; sel_high = h; start = 1'b1;
        lat = -1; stalls = 0; res = 32'hDEAD_BEEF;
        @(negedge clk);
        if (o_stall) stalls++;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (o_stall) stalls++;
            if (o_done) begin
                lat = k;
                res = o_result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        src1 = '0; src2 = '0; s1 = 1'b0; s2 = 1'b0; sel_high = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({o_stall, o_busy, o_done} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {o_stall, o_busy, o_done}); else pass_cnt++;
        chk_cnt++; if (o_result !== 32'h0) $display("FAIL reset_result got=%h want=00000000", o_result); else pass_cnt++;
    endtask

    task automatic test_mul_latency;
        logic [31:0] r; int lat; int st;
        do_mul(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, r, lat, st);
        chk_cnt++; if (r !== 32'hFFFF_FFEB) $display("FAIL mul_7xm3 got=%h want=ffffffeb", r); else pass_cnt++;
        chk_cnt++; if (lat !== 33) $display("FAIL mul_latency got=%0d want=33", lat); else pass_cnt++;
        chk_cnt++; if (st !== 33) $display("FAIL mul_stall_cycles got=%0d want=33", st); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({o_done, o_busy} !== 2'b00) $display("FAIL done_single_pulse got=%b want=00", {o_done, o_busy}); else pass_cnt++;
        chk_cnt++; if (o_result !== 32'hFFFF_FFEB) $display("FAIL result_hold got=%h want=ffffffeb", o_result); else pass_cnt++;
    endtask

    task automatic test_high_variants;
        logic [31:0] r; int lat; int st;
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, r, lat, st);
        chk_cnt++; if (r !== 32'h4000_0000) $display("FAIL mulh_minmin got=%h want=40000000", r); else pass_cnt++;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, r, lat, st);
        chk_cnt++; if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu_ones got=%h want=fffffffe", r); else pass_cnt++;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, r, lat, st);
        chk_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu_hi got=%h want=ffffffff", r); else pass_cnt++;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, r, lat, st);
        chk_cnt++; if (r !== 32'h0000_0001) $display("FAIL mulhsu_lo got=%h want=00000001", r); else pass_cnt++;
        do_mul(32'hFFFF_FFF9, 32'd5, 1'b1, 1'b1, 1'b1, r, lat, st);
        chk_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulh_m7x5 got=%h want=ffffffff", r); else pass_cnt++;
        do_mul(32'h1234_5678, 32'h10, 1'b0, 1'b0, 1'b0, r, lat, st);
        chk_cnt++; if (r !== 32'h2345_6780) $display("FAIL mul_shift got=%h want=23456780", r); else pass_cnt++;
    endtask

    task automatic test_zero_fast;
        logic [31:0] r; int lat; int st;
        do_mul(32'h0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, r, lat, st);
        chk_cnt++; if (r !== 32'h0) $display("FAIL zero_result got=%h want=00000000", r); else pass_cnt++;
        chk_cnt++; if (lat !== 1) $display("FAIL zero_latency got=%0d want=1", lat); else pass_cnt++;
        chk_cnt++; if (st !== 1) $display("FAIL zero_stall_cycles got=%0d want=1", st); else pass_cnt++;
    endtask

    task automatic test_flush;
        logic [31:0] r; int lat; int st; int done_seen;
        do_mul(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, r, lat, st);
        chk_cnt++; if (r !== 32'd12) $display("FAIL pre_flush got=%h want=0000000c", r); else pass_cnt++;
        done_seen = 0;
        @(posedge clk); #1;
        src1 = 32'd9; src2 = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk); if (o_done) done_seen++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk); if (o_done) done_seen++;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({o_busy, o_stall} !== 2'b00) $display("FAIL flush_idle got=%b want=00", {o_busy, o_stall}); else pass_cnt++;
        chk_cnt++; if (o_result !== 32'd12) $display("FAIL flush_result_kept got=%h want=0000000c", o_result); else pass_cnt++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); if (o_done) done_seen++;
        end
        chk_cnt++; if (done_seen !== 0) $display("FAIL flush_no_done got=%0d want=0", done_seen); else pass_cnt++;
        do_mul(32'hFFFF_FFFE, 32'd6, 1'b1, 1'b0, 1'b0, r, lat, st);
        chk_cnt++; if (r !== 32'hFFFF_FFF4) $display("FAIL post_flush got=%h want=fffffff4", r); else pass_cnt++;
        chk_cnt++; if (lat !== 33) $display("FAIL post_flush_latency got=%0d want=33", lat); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int t; int first_done; int second_done; int stall_in_done; logic [31:0] r1;
        first_done = -1; second_done = -1; stall_in_done = -1; r1 = '0;
        @(posedge clk); #1;
        src1 = 32'd100; src2 = 32'd200; s1 = 1'b0; s2 = 1'b0; sel_high = 1'b0; start = 1'b1;
        for (t = 0; t < 120; t++) begin
            @(negedge clk);
            if (o_done && first_done < 0) begin
                first_done = t; r1 = o_result; stall_in_done = int'(o_stall);
            end else if (o_done) begin
                second_done = t;
                break;
            end
            @(posedge clk); #1;
            // Second op is accepted at T+34; change operands at T+36, mid-CALC, which must be ignored.
            if (first_done >= 0 && t == first_done + 2) begin
                src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
            end
        end
        start = 1'b0;
        chk_cnt++; if (first_done !== 33) $display("FAIL b2b_first_latency got=%0d want=33", first_done); else pass_cnt++;
        chk_cnt++; if (r1 !== 32'd20000) $display("FAIL b2b_first_result got=%0d want=20000", r1); else pass_cnt++;
        chk_cnt++; if (stall_in_done !== 0) $display("FAIL b2b_stall_in_done got=%0d want=0", stall_in_done); else pass_cnt++;
        chk_cnt++; if (second_done !== 67) $display("FAIL b2b_second_latency got=%0d want=67", second_done); else pass_cnt++;
        chk_cnt++; if (o_result !== 32'd20000) $display("FAIL b2b_operand_change got=%h want=00004e20", o_result); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int done_seen;
        done_seen = 0;
        @(posedge clk); #1;
        src1 = 32'd11; src2 = 32'd13; s1 = 1'b0; s2 = 1'b0; sel_high = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({o_stall, o_busy, o_done} !== 3'b000) $display("FAIL rst_mid_flags got=%b want=000", {o_stall, o_busy, o_done}); else pass_cnt++;
        chk_cnt++; if (o_result !== 32'h0) $display("FAIL rst_mid_result got=%h want=00000000", o_result); else pass_cnt++;
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk_cnt++; if (o_stall !== 1'b0) $display("FAIL start_flush_stall got=%b want=0", o_stall); else pass_cnt++;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); if (o_done || o_busy) done_seen++;
        end
        chk_cnt++; if (done_seen !== 0) $display("FAIL start_flush_no_op got=%0d want=0", done_seen); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_mul_latency;
        test_high_variants;
        test_zero_fast;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
